r2r_dac_wavegen: RTL

//  Parametrised next-generation R2R DAC controller: drives a DATA_W-bit code to the off-chip/analog R2R ladder.

---
 rtl/r2r_dac_wavegen_if.sv | 28 ++
 rtl/r2r_dac_wavegen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/r2r_dac_wavegen_if.sv
// ============================================================================
// r2r_dac_wavegen_if : data/control/output bundle for the R2R DAC wave generator
// Revision 1.0
// ============================================================================
`default_nettype none

interface r2r_dac_wavegen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic [1:0]        mode;
  logic              load_divider;
  logic              wr_en;
  logic [DATA_W-1:0] r2r_out;
  logic              tick;

  modport master (
    output data, mode, load_divider, wr_en,
    input  r2r_out, tick
  );

  modport slave (
    input  data, mode, load_divider, wr_en,
    output r2r_out, tick
  );
endinterface

`default_nettype wire

// File: rtl/r2r_dac_wavegen.sv
// ============================================================================
// r2r_dac_wavegen : R2R ladder code generator (EXT/SAW/TRI/RAM) with rate divider
// Revision 1.0
// ============================================================================
`default_nettype none

module r2r_dac_wavegen #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter int DIV_SHIFT = 0,
  parameter int DIV_RESET = 9,
  parameter int DEPTH     = 16
) (
  input  wire logic           clk,
  input  wire logic           n_rst,
  r2r_dac_wavegen_if.slave    bus
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] CODE_MAX = '1;
  localparam logic [1:0]        MODE_EXT = 2'd0;
  localparam logic [1:0]        MODE_SAW = 2'd1;
  localparam logic [1:0]        MODE_TRI = 2'd2;

  typedef enum logic [0:0] {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [DIV_W-1:0]  div_reload_q, div_reload_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]  load_val;
  logic              tick_q, tick_d;
  logic [DATA_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0] r2r_q, r2r_d;
  dir_e              dir_q, dir_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // The waveform steps on the same edge that raises tick, so tick_d is the step strobe.
  always_comb begin
    load_val     = DIV_W'(bus.data) << DIV_SHIFT;
    div_reload_d = div_reload_q;
    div_cnt_d    = div_cnt_q - DIV_W'(1);
    tick_d       = 1'b0;
    if (bus.load_divider) begin
      div_reload_d = load_val;
      div_cnt_d    = load_val;
    end else if (div_cnt_q == '0) begin
      tick_d    = 1'b1;
      div_cnt_d = div_reload_q;
    end

    phase_d  = phase_q;
    dir_d    = dir_q;
    rd_ptr_d = rd_ptr_q;
    r2r_d    = r2r_q;
    if (bus.mode != mode_q) begin
      phase_d  = '0;
      dir_d    = DIR_UP;
      rd_ptr_d = '0;
      r2r_d    = '0;
    end else begin
      case (mode_q)
        MODE_EXT: r2r_d = bus.data;
        MODE_SAW: begin
          if (tick_d) begin
            phase_d = phase_q + DATA_W'(1);
            r2r_d   = phase_d;
          end
        end
        MODE_TRI: begin
          if (tick_d) begin
            if (dir_q == DIR_UP) begin
              phase_d = phase_q + DATA_W'(1);
              if (phase_d == CODE_MAX) dir_d = DIR_DOWN;
            end else begin
              phase_d = phase_q - DATA_W'(1);
              if (phase_d == '0) dir_d = DIR_UP;
            end
            r2r_d = phase_d;
          end
        end
        default: begin
          if (tick_d) begin
            r2r_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      endcase
    end

    wr_ptr_d = bus.wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      div_reload_q <= DIV_W'(DIV_RESET);
      div_cnt_q    <= DIV_W'(DIV_RESET);
      tick_q       <= 1'b0;
      phase_q      <= '0;
      dir_q        <= DIR_UP;
      r2r_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mode_q       <= MODE_EXT;
    end else begin
      div_reload_q <= div_reload_d;
      div_cnt_q    <= div_cnt_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      r2r_q        <= r2r_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mode_q       <= bus.mode;
    end
  end

  // Sample RAM keeps its contents through reset; writes are only blocked while reset is held.
  always_ff @(posedge clk) begin
    if (n_rst && bus.wr_en) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.r2r_out = r2r_q;
  assign bus.tick    = tick_q;

endmodule

`default_nettype wire
